// File: rtl/fsm_run_monitor.sv
// fsm_run_monitor
//
// Watches the 2-bit state of the consecutive-ones detector FSM, where
// A=00, B=01, C=10 and D=11. For each run of non-A states it measures the
// run length and counts the D samples. A D sample marks a completed triple
// of ones. When a run ends and it contains at least one triple, the monitor
// pushes the record {triples, run_len} into a small FIFO. A consumer drains
// that FIFO over a valid/ready handshake.
//
// Parameters
//   LW     run-length field width
//   TW     triple-count field width
//   DEPTH  record FIFO depth (power of 2, >= 2)
//
// Ports
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   state          FSM state, sampled on every edge
//   out_ready      consumer accepts the head record
//   out_valid      FIFO holds at least one record
//   out_data       head record {triples[TW-1:0], run_len[LW-1:0]}
//   total_triples  D samples seen since reset, wraps mod 2^16
//   overflow       sticky; set when a record is dropped on a full FIFO
//   drop_count     saturating count of dropped records; exists only when
//                  FSM_RUN_MON_DROP_CNT_EN is defined
//
// Build option: defining FSM_RUN_MON_DROP_CNT_EN adds the drop_count port
// and its counter. All other behaviour is unchanged.

module fsm_run_monitor #(
  parameter int LW    = 8,
  parameter int TW    = 6,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           state,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [TW+LW-1:0]     out_data,
  output logic [15:0]          total_triples,
  output logic                 overflow
`ifdef FSM_RUN_MON_DROP_CNT_EN
  ,
  output logic [7:0]           drop_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] ST_A = 2'b00;
  localparam logic [1:0] ST_D = 2'b11;

  function automatic logic [LW-1:0] sat_inc_len(input logic [LW-1:0] v);
    return (v == {LW{1'b1}}) ? v : v + LW'(1);
  endfunction

  function automatic logic [TW-1:0] sat_inc_tri(input logic [TW-1:0] v);
    return (v == {TW{1'b1}}) ? v : v + TW'(1);
  endfunction

  logic [LW-1:0]    r_run_len;
  logic [TW-1:0]    r_tri;
  logic [15:0]      r_total;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [TW+LW-1:0] r_mem [DEPTH];
  logic             r_overflow;

  logic             w_empty;
  logic             w_full;
  logic             w_run_end;
  logic             w_push;
  logic             w_pop;
  logic             w_wr_en;
  logic             w_drop;
  logic [TW+LW-1:0] w_rec;

  // Run measurement stage: one sample of state per edge
  assign w_run_end = (state == ST_A) && (r_run_len != '0);
  assign w_push    = w_run_end && (r_tri != '0);
  assign w_rec     = {r_tri, r_run_len};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_len <= '0;
      r_tri     <= '0;
      r_total   <= '0;
    end else if (state != ST_A) begin
      r_run_len <= sat_inc_len(r_run_len);
      if (state == ST_D) begin
        r_tri   <= sat_inc_tri(r_tri);
        r_total <= r_total + 16'd1;
      end
    end else if (w_run_end) begin
      r_run_len <= '0;
      r_tri     <= '0;
    end
  end

  // Record FIFO stage: the extra pointer MSB tells full from empty
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && out_ready;
  // A simultaneous pop frees the head slot, so a push to a full FIFO still lands.
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      if (w_drop)  r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_rec;
  end

`ifdef FSM_RUN_MON_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_count = r_drop_cnt;
`endif

  // Output stage: driven only from registers
  assign out_valid     = !w_empty;
  // Masking while empty keeps the unreset storage from showing on the port.
  assign out_data      = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign total_triples = r_total;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_fsm_run_monitor.sv
module tb_fsm_run_monitor;

  localparam int LW    = 8;
  localparam int TW    = 6;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        state = 2'b00;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [TW+LW-1:0]  out_data;
  logic [15:0]       total_triples;
  logic              overflow;
`ifdef FSM_RUN_MON_DROP_CNT_EN
  logic [7:0]        drop_count;
`endif

  fsm_run_monitor #(.LW(LW), .TW(TW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .state         (state),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .total_triples (total_triples),
    .overflow      (overflow)
`ifdef FSM_RUN_MON_DROP_CNT_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one record per completed run with triples, in an unbounded-counter form
  int          m_len   = 0;
  int          m_tri   = 0;
  int          m_total = 0;
  int          m_drop  = 0;
  bit          m_ovf   = 1'b0;
  int          m_q[$];

  always @(posedge clk) begin
    bit do_pop;
    bit do_push;
    int rec;
    if (reset) begin
      m_len = 0; m_tri = 0; m_total = 0; m_drop = 0; m_ovf = 1'b0;
      m_q.delete();
    end else begin
      do_pop  = (m_q.size() != 0) && out_ready;
      do_push = 1'b0;
      rec     = 0;
      if (state != 2'b00) begin
        m_len++;
        if (state == 2'b11) begin
          m_tri++;
          m_total = (m_total + 1) % 65536;
        end
      end else if (m_len != 0) begin
        if (m_tri != 0) begin
          do_push = 1'b1;
          rec = ((m_tri > 63) ? 63 : m_tri) * 256 + ((m_len > 255) ? 255 : m_len);
        end
        m_len = 0;
        m_tri = 0;
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(rec);
        else begin
          m_ovf = 1'b1;
          m_drop++;
        end
      end
    end
  end

  // Compare process: every cycle once reset has been applied
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", int'(out_valid), (m_q.size() != 0) ? 1 : 0);
      if (m_q.size() != 0) chk("out_data", int'(out_data), m_q[0]);
      chk("total_triples", int'(total_triples), m_total);
      chk("overflow", int'(overflow), int'(m_ovf));
`ifdef FSM_RUN_MON_DROP_CNT_EN
      chk("drop_count", int'(drop_count), (m_drop > 255) ? 255 : m_drop);
`endif
    end
  end

  task automatic step(input logic [1:0] s, input logic rdy, input logic rst);
    state     = s;
    out_ready = rdy;
    reset     = rst;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_bcda(input logic rdy);
    step(2'b01, rdy, 1'b0);
    step(2'b10, rdy, 1'b0);
    step(2'b11, rdy, 1'b0);
    step(2'b00, rdy, 1'b0);
  endtask

  initial begin
    chk_en = 1'b1;
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_total", int'(total_triples), 0);
    chk("rst_ovf", int'(overflow), 0);

    // Single triple
    run_bcda(1'b0);
    chk("single_valid", int'(out_valid), 1);
    chk("single_data", int'(out_data), 'h0103);
    chk("single_total", int'(total_triples), 1);
    step(2'b00, 1'b1, 1'b0);
    chk("single_drained", int'(out_valid), 0);

    // Run without triple
    step(2'b01, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    chk("notri_valid", int'(out_valid), 0);

    // Long run with two triples
    for (int i = 0; i < 2; i++) begin
      step(2'b01, 1'b0, 1'b0);
      step(2'b10, 1'b0, 1'b0);
      step(2'b11, 1'b0, 1'b0);
    end
    step(2'b01, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    chk("long_data", int'(out_data), 'h0207);
    step(2'b00, 1'b1, 1'b0);

    // Saturating run: 300 samples, 100 of them D
    for (int i = 0; i < 100; i++) begin
      step(2'b01, 1'b0, 1'b0);
      step(2'b10, 1'b0, 1'b0);
      step(2'b11, 1'b0, 1'b0);
    end
    step(2'b00, 1'b0, 1'b0);
    chk("sat_data", int'(out_data), 'h3FFF);
    chk("sat_total", int'(total_triples), 103);
    step(2'b00, 1'b1, 1'b0);

    // Overflow: five runs into a four-deep FIFO with no consumer
    for (int i = 0; i < 5; i++) run_bcda(1'b0);
    chk("ovf_flag", int'(overflow), 1);
`ifdef FSM_RUN_MON_DROP_CNT_EN
    chk("ovf_drop", int'(drop_count), 1);
`endif
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", int'(out_valid), 1);
      chk("drain_data", int'(out_data), 'h0103);
      step(2'b00, 1'b1, 1'b0);
    end
    chk("drain_empty", int'(out_valid), 0);

    // Full FIFO, push and pop on the same edge
    step(2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) run_bcda(1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    chk("pp_ovf", int'(overflow), 0);
    chk("pp_occupancy", m_q.size(), 4);
    for (int i = 0; i < 4; i++) step(2'b00, 1'b1, 1'b0);
    chk("pp_drained", int'(out_valid), 0);

    // Reset mid-run with records pending
    run_bcda(1'b0);
    run_bcda(1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b1);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_total", int'(total_triples), 0);
    step(2'b11, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    chk("midrst_rec", int'(out_data), 'h0101);
    step(2'b00, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [1:0] s;
      logic       r;
      logic       rs;
      s  = 2'($urandom_range(0, 3));
      r  = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      rs = ($urandom_range(0, 299) == 0);
      step(s, r, rs);
    end

    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
